// File: rtl/lsu_pkg.sv
// Shared codes for the LSU pointer controller and the register file pointer port.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_UPD   = 2'd2
    } lsu_state_e;

    localparam logic [1:0] RH_OP_NONE = 2'b00;
    localparam logic [1:0] RH_OP_INC  = 2'b01;
    localparam logic [1:0] RH_OP_DEC  = 2'b10;

    localparam logic [1:0] PTR_X = 2'd0;
    localparam logic [1:0] PTR_Y = 2'd1;
    localparam logic [1:0] PTR_Z = 2'd2;

    localparam logic [1:0] PMODE_PLAIN   = 2'd0;
    localparam logic [1:0] PMODE_POSTINC = 2'd1;
    localparam logic [1:0] PMODE_PREDEC  = 2'd2;

    // Reserved selector 3 aliases the Z pair.
    function automatic logic [1:0] map_ptr_sel(input logic [1:0] sel);
        return (sel == 2'd3) ? PTR_Z : sel;
    endfunction

    // Reserved mode 3 behaves as a plain access.
    function automatic logic [1:0] map_ptr_mode(input logic [1:0] mode);
        return (mode == 2'd3) ? PMODE_PLAIN : mode;
    endfunction

    function automatic logic [1:0] mode_to_rh_op(input logic [1:0] mode);
        logic [1:0] op;
        case (mode)
            PMODE_POSTINC: op = RH_OP_INC;
            PMODE_PREDEC:  op = RH_OP_DEC;
            default:       op = RH_OP_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Counts consecutive cycles with run high; flags the last allowed cycle.
module lsu_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Counter is zero in the first run cycle and saturates at the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!run) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = run && (cnt_q == LAST);

endmodule

// File: rtl/lsu_ptr_ctrl.sv
// Indirect load/store through X/Y/Z pointer pairs with pointer post-inc / pre-dec.
// Optional request timeout is built when LSU_TIMEOUT_EN is defined.
module lsu_ptr_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        ptr_sel,
    input  logic [1:0]        ptr_mode,
    input  logic [4:0]        reg_sel,
    input  logic [ADDR_W-1:0] ptr_val,
    input  logic [7:0]        st_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        rh_sel,
    output logic [1:0]        rh_op,
    output logic              rf_wr_en,
    output logic [4:0]        rf_wr_sel,
    output logic [7:0]        rf_wr_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    logic [1:0]        sel_q, sel_d;
    logic [1:0]        mode_q, mode_d;
    logic [4:0]        reg_q, reg_d;
    logic              timeout_c;
    logic              abort_d;

    logic              busy_d, done_d, err_d, rf_wr_en_d, mem_req_d, mem_we_d;
    logic [1:0]        rh_sel_d, rh_op_d;
    logic [4:0]        rf_wr_sel_d;
    logic [7:0]        rf_wr_data_d, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_d;

`ifdef LSU_TIMEOUT_EN
    lsu_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q == ST_ISSUE),
        .expired_c (timeout_c)
    );
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_c      = 1'b0;
`endif

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        sel_d        = sel_q;
        mode_d       = mode_q;
        reg_d        = reg_q;
        mem_we_d     = mem_we;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        rf_wr_data_d = '0;
        abort_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ISSUE;
                    store_d     = is_store;
                    sel_d       = map_ptr_sel(ptr_sel);
                    mode_d      = map_ptr_mode(ptr_mode);
                    reg_d       = reg_sel;
                    mem_we_d    = is_store;
                    mem_wdata_d = st_data;
                    mem_addr_d  = (map_ptr_mode(ptr_mode) == PMODE_PREDEC)
                                  ? ptr_val - ADDR_W'(1) : ptr_val;
                end
            end
            ST_ISSUE: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d      = ST_UPD;
                    rf_wr_data_d = mem_rdata;
                end else if (timeout_c) begin
                    state_d = ST_UPD;
                    abort_d = 1'b1;
                end
            end
            ST_UPD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        mem_req_d   = (state_d == ST_ISSUE);
        done_d      = (state_d == ST_UPD) && (state_q == ST_ISSUE);
        err_d       = done_d && abort_d;
        rf_wr_en_d  = done_d && !abort_d && !store_d;
        rf_wr_sel_d = rf_wr_en_d ? reg_d : 5'd0;
        if (!rf_wr_en_d) begin
            rf_wr_data_d = '0;
        end
        rh_sel_d    = done_d ? sel_d : PTR_X;
        rh_op_d     = (done_d && !abort_d) ? mode_to_rh_op(mode_d) : RH_OP_NONE;
    end

    // State, captured command and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            store_q    <= 1'b0;
            sel_q      <= '0;
            mode_q     <= '0;
            reg_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            rh_sel     <= '0;
            rh_op      <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_sel  <= '0;
            rf_wr_data <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            sel_q      <= sel_d;
            mode_q     <= mode_d;
            reg_q      <= reg_d;
            busy       <= busy_d;
            done       <= done_d;
            err        <= err_d;
            rh_sel     <= rh_sel_d;
            rh_op      <= rh_op_d;
            rf_wr_en   <= rf_wr_en_d;
            rf_wr_sel  <= rf_wr_sel_d;
            rf_wr_data <= rf_wr_data_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

endmodule
